// File: rtl/sqta_pkg.sv
// Shared definitions for the SQTA microcode loader and the SQTA sequencer.
// Microinstruction layout (11 bits):
//   TEST[10:9] NS_FALSE[8:6] NS_TRUE[5:3] Z[2:0]
package sqta_pkg;

  localparam int WORD_W = 11;
  localparam int ROWS   = 7;
  localparam int ADDR_W = 3;

  // Field bit positions inside a microinstruction word
  localparam int TEST_HI = 10;
  localparam int TEST_LO = 9;
  localparam int NSF_HI  = 8;
  localparam int NSF_LO  = 6;
  localparam int NST_HI  = 5;
  localparam int NST_LO  = 3;
  localparam int Z_HI    = 2;
  localparam int Z_LO    = 0;
  localparam int FLD_W   = 3;   // width of a next-state field

  typedef struct packed {
    logic [1:0]       test;
    logic [FLD_W-1:0] ns_false;
    logic [FLD_W-1:0] ns_true;
    logic [2:0]       z;
  } uinst_t;

  // ErrRow code reported when the readback checksum does not match
  localparam logic [2:0] ERR_ROW_CHK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_e;

endpackage

// File: rtl/sqta_ser2par.sv
// Serial-to-parallel shifter for microcode words, MSB first.
// Ports:
//   Clk, Rst       clock, synchronous active-low reset
//   clr            restart the word (new session)
//   en             loader is in its shift phase
//   ser_in         serial bit
//   ser_valid      ser_in valid this cycle
//   word           assembled word (newest bit at LSB)
//   word_done      combinational pulse on the cycle the last bit is accepted
module sqta_ser2par #(
  parameter int WORD_W = 11
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              en,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [CNT_W-1:0] bitcnt;
  logic             take;

  assign take      = en && ser_valid;
  assign word_done = take && (bitcnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge Clk) begin
    if (!Rst || clr) begin
      word   <= '0;
      bitcnt <= '0;
    end else if (take) begin
      word   <= {word[WORD_W-2:0], ser_in};
      // counter rearms by itself so the next row starts from zero
      bitcnt <= word_done ? '0 : bitcnt + 1'b1;
    end
  end

endmodule

// File: rtl/sqta_ucode_loader.sv
// SQTA microcode loader: receives ROWS serial microinstructions, checks their
// next-state fields, writes them to the microcode RAM, then reads the RAM back
// and compares an XOR checksum against the one taken while writing.
// Ports:
//   Clk, Rst              clock, synchronous active-low reset
//   Start                 begin a session (honoured only in IDLE/DONE/ERR)
//   SerIn/SerValid/SerReady  serial word stream, MSB first
//   MemWe/MemAddr/MemWData   RAM write port; MemAddr also drives readback
//   MemRData              RAM read data, combinational from MemAddr
//   Busy/Done/Err         session status
//   ErrRow                failing row, or 3'b111 on checksum mismatch
module sqta_ucode_loader #(
  parameter int WORD_W = sqta_pkg::WORD_W,
  parameter int ROWS   = sqta_pkg::ROWS,
  parameter int ADDR_W = sqta_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              SerIn,
  input  logic              SerValid,
  output logic              SerReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [WORD_W-1:0] MemWData,
  input  logic [WORD_W-1:0] MemRData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] ErrRow
);
  import sqta_pkg::*;

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS - 1);
  localparam logic [FLD_W-1:0]  NS_MAX = FLD_W'(ROWS - 1);

  ld_state_e         state, state_nx;
  logic [ADDR_W-1:0] row, rd, err_row;
  logic [WORD_W-1:0] chk, rchk, word;
  logic              word_done, legal, start_go;

  // Start is only honoured when no session is running
  assign start_go = Start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  // Both next-state targets must address an existing row
  assign legal = (word[NSF_HI:NSF_LO] <= NS_MAX) && (word[NST_HI:NST_LO] <= NS_MAX);

  assign ErrRow = err_row;

  sqta_ser2par #(.WORD_W(WORD_W)) u_s2p (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (start_go),
    .en        (state == ST_SHIFT),
    .ser_in    (SerIn),
    .ser_valid (SerValid),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_nx = state;
    SerReady = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    case (state)
      ST_IDLE: if (Start) state_nx = ST_SHIFT;
      ST_SHIFT: begin
        Busy     = 1'b1;
        SerReady = 1'b1;
        if (word_done) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        Busy = 1'b1;
        if (legal) begin
          MemWe    = 1'b1;
          MemAddr  = row;
          MemWData = word;
          state_nx = (row == LAST) ? ST_VERIFY : ST_SHIFT;
        end else begin
          state_nx = ST_ERR;
        end
      end
      ST_VERIFY: begin
        Busy    = 1'b1;
        MemAddr = rd;
        if (rd == LAST) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        Busy     = 1'b1;
        state_nx = (rchk == chk) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) state_nx = ST_SHIFT;
      end
      ST_ERR: begin
        Err = 1'b1;
        if (Start) state_nx = ST_SHIFT;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      row     <= '0;
      rd      <= '0;
      chk     <= '0;
      rchk    <= '0;
      err_row <= '0;
    end else begin
      state <= state_nx;
      if (start_go) begin
        row     <= '0;
        rd      <= '0;
        chk     <= '0;
        rchk    <= '0;
        err_row <= '0;
      end else begin
        case (state)
          ST_WRITE: begin
            if (legal) begin
              chk <= chk ^ word;
              // row saturates at LAST; verify pass starts from row 0
              if (row != LAST) row <= row + 1'b1;
              else             rd  <= '0;
            end else begin
              err_row <= row;
            end
          end
          ST_VERIFY: begin
            rchk <= rchk ^ MemRData;
            if (rd != LAST) rd <= rd + 1'b1;
          end
          ST_CHECK: if (rchk != chk) err_row <= ADDR_W'(ERR_ROW_CHK);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqta_ucode_loader.sv
module tb_sqta_ucode_loader;

  logic        Clk = 1'b0, Rst = 1'b0, Start = 1'b0, SerIn = 1'b0, SerValid = 1'b0;
  logic        SerReady, MemWe, Busy, Done, Err;
  logic [2:0]  MemAddr, ErrRow;
  logic [10:0] MemWData, MemRData;

  sqta_ucode_loader dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .SerIn(SerIn), .SerValid(SerValid),
    .SerReady(SerReady), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .Busy(Busy), .Done(Done), .Err(Err), .ErrRow(ErrRow)
  );

  always #5 Clk = ~Clk;

  // RAM model with optional bit-0 corruption of one row on readback
  logic [10:0] mem [0:7];
  bit          flip_en = 1'b0;
  logic [2:0]  flip_addr = 3'd0;
  always @(posedge Clk) if (MemWe) mem[MemAddr] <= MemWData;
  assign MemRData = mem[MemAddr] ^ ((flip_en && flip_addr == MemAddr) ? 11'd1 : 11'd0);

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [10:0] data; int cy; } wr_t;
  typedef struct { bit done; bit err; int row; int cy; } out_t;
  wr_t  exp_w [$];
  out_t exp_o [$];

  logic [10:0] words [7];
  logic [10:0] ref_words [7] = '{11'b01001010000, 11'b11110101100, 11'b10011101000,
                                 11'b00100100010, 11'b01000100100, 11'b00000000001,
                                 11'b10101000010};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and every Done/Err rising edge is popped
  // from the scoreboard and compared.
  logic pd = 1'b0, pe = 1'b0;
  always @(negedge Clk) begin
    int rel;
    rel = cyc + 1 - start_cyc;
    if (Rst) begin
      if (MemWe) begin
        chk("write_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          wr_t e;
          e = exp_w.pop_front();
          chk("wr_addr", MemAddr, e.addr);
          chk("wr_data", MemWData, e.data);
          if (e.cy >= 0) chk("wr_cycle", rel, e.cy);
        end
      end
      if ((Done && !pd) || (Err && !pe)) begin
        chk("outcome_expected", exp_o.size() != 0, 1);
        if (exp_o.size() != 0) begin
          out_t o;
          o = exp_o.pop_front();
          chk("out_done", Done, o.done);
          chk("out_err", Err, o.err);
          chk("out_busy", Busy, 0);
          if (o.err) chk("out_errrow", ErrRow, o.row);
          if (o.cy >= 0) chk("out_cycle", rel, o.cy);
        end
      end
    end
    pd <= Done;
    pe <= Err;
  end

  // Reference model: rows are written in order until the first word whose
  // next-state fields point past the last row; a gapless stream costs 12
  // cycles per row, then 7 verify cycles + 1 check cycle.
  task automatic model(input int gap, output int nsend);
    int bad = -1;
    logic [10:0] wx = 0, rx = 0;
    for (int r = 0; r < 7; r++) begin
      if (bad < 0) begin
        if (words[r][8:6] > 3'd6 || words[r][5:3] > 3'd6) bad = r;
        else begin
          exp_w.push_back('{r, words[r], (gap == 0) ? 12 * (r + 1) : -1});
          wx ^= words[r];
          rx ^= words[r] ^ ((flip_en && flip_addr == r[2:0]) ? 11'd1 : 11'd0);
        end
      end
    end
    if (bad >= 0) begin
      exp_o.push_back('{1'b0, 1'b1, bad, (gap == 0) ? 12 * (bad + 1) + 1 : -1});
      nsend = bad + 1;
    end else begin
      if (wx == rx) exp_o.push_back('{1'b1, 1'b0, 0, (gap == 0) ? 93 : -1});
      else          exp_o.push_back('{1'b0, 1'b1, 7, (gap == 0) ? 93 : -1});
      nsend = 7;
    end
  endtask

  task automatic start_session();
    Start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic send_bit(input logic v, input bit pulse);
    int n = 0;
    SerIn = v;
    SerValid = 1'b1;
    if (pulse) Start = 1'b1;
    while (!SerReady && n < 64) begin @(negedge Clk); n++; end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL serready_timeout: SerReady stayed low for %0d cycles", n);
    end
    @(posedge Clk);
    @(negedge Clk);
    SerValid = 1'b0;
    Start = 1'b0;
  endtask

  task automatic send_word(input logic [10:0] w, input int gap, input int pulse_bit);
    for (int b = 10; b >= 0; b--) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        SerValid = 1'b0;
        if (b != 10) chk("serready_in_gap", SerReady, 1);
        @(negedge Clk);
      end
      send_bit(w[b], b == pulse_bit);
    end
  endtask

  task automatic wait_outcome();
    int n = 0;
    while (!(Done || Err) && n < 400) begin @(negedge Clk); n++; end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL outcome_timeout: no Done/Err after %0d cycles", n);
    end
    @(negedge Clk);
    chk("writes_drained", exp_w.size(), 0);
    chk("outcomes_drained", exp_o.size(), 0);
  endtask

  task automatic run_session(input int gap, input int pulse_row);
    int nsend;
    model(gap, nsend);
    start_session();
    for (int r = 0; r < nsend; r++) send_word(words[r], gap, (r == pulse_row) ? 5 : -1);
    wait_outcome();
  endtask

  task automatic check_idle(input string name);
    chk(name, {SerReady, MemWe, Busy, Done, Err, ErrRow, MemAddr, MemWData}, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 11'(i * 37 + 5);
    repeat (3) @(negedge Clk);
    check_idle("reset_outputs");
    Rst = 1'b1;
    @(negedge Clk);
    check_idle("idle_after_reset");

    // gapless reference stream
    words = ref_words;
    run_session(0, -1);
    // SerValid low every other cycle
    run_session(1, -1);
    // row 3 with NS_FALSE=7
    words[3] = 11'b00111000000;
    run_session(0, -1);
    words = ref_words;
    // readback corruption of row 5
    flip_en = 1'b1; flip_addr = 3'd5;
    run_session(0, -1);
    flip_en = 1'b0;
    // Start pulse during row 1 must be ignored
    run_session(0, 1);

    // reset after 5 bits of row 2
    begin
      int nsend;
      model(0, nsend);
      exp_w = exp_w[0:1];
      exp_o.delete();
      start_session();
      send_word(words[0], 0, -1);
      send_word(words[1], 0, -1);
      for (int b = 10; b > 5; b--) send_bit(words[2][b], 1'b0);
      Rst = 1'b0;
      @(negedge Clk);
      check_idle("reset_mid_shift");
      Rst = 1'b1;
      repeat (20) @(negedge Clk);
      chk("idle_after_abort", {Busy, Done, Err, MemWe}, 0);
      chk("abort_writes_drained", exp_w.size(), 0);
      run_session(0, -1);
    end

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      for (int r = 0; r < 7; r++) begin
        words[r] = 11'($urandom);
        if ($urandom_range(0, 6) != 0) begin
          words[r][8:6] = 3'($urandom_range(0, 6));
          words[r][5:3] = 3'($urandom_range(0, 6));
        end
      end
      flip_en   = ($urandom_range(0, 3) == 0);
      flip_addr = 3'($urandom_range(0, 6));
      run_session($urandom_range(0, 2), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
